fetch_stage_controller: RTL and testbench

- Front-end consumer of the load-use hazard stall signals (pc_write, if_id_write) and the EX-stage branch redirect.
- Owns the PC register, the instruction-memory request handshake, a one-entry hold buffer, and the IF/ID pipeline register.
- Turns stall and flush requests into the correct IF/ID contents: a held instruction, a bubble, or a new instruction.

---
 rtl/fetch_stage_controller.sv | 168 ++++++++++++++++
 tb/tb_fetch_stage_controller.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage_controller.sv
// -----------------------------------------------------------------------------
// fetch_stage_controller
//
// Instruction-fetch front end. Owns the fetch PC, the instruction-memory
// request handshake, a one-entry hold buffer and the IF/ID pipeline register.
// Load-use stalls (pc_write_i / if_id_write_i) and EX-stage branch redirects
// are turned into IF/ID contents: a held instruction, a bubble, or a new one.
//
// state    | meaning
// ---------+-------------------------------------------------------------------
// FETCH    | request outstanding at pc; data goes to IF/ID or the hold buffer
// HOLD     | one instruction buffered while IF/ID is stalled; no request
// DISCARD  | abandoned request still outstanding at the old address; data dropped
//
// Ports
//   clk_i            rising-edge clock
//   reset_i          synchronous active-high reset
//   pc_write_i       1 = PC may advance
//   if_id_write_i    1 = IF/ID may load
//   branch_taken_i   redirect from EX, flushes fetch
//   branch_target_i  redirect address
//   imem_req_o       instruction-memory request
//   imem_addr_o      request address, stable until the transfer
//   imem_ready_i     memory accepts request / returns data this cycle
//   imem_rdata_i     instruction data, valid on imem_req_o & imem_ready_i
//   pc_o             current fetch PC
//   if_id_pc_o       PC of the instruction in IF/ID
//   if_id_instr_o    instruction in IF/ID
//   if_id_valid_o    1 = real instruction, 0 = bubble
// -----------------------------------------------------------------------------
module fetch_stage_controller #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned           PC_STEP     = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   pc_write_i,
  input  logic                   if_id_write_i,
  input  logic                   branch_taken_i,
  input  logic [ADDR_WIDTH-1:0]  branch_target_i,
  output logic                   imem_req_o,
  output logic [ADDR_WIDTH-1:0]  imem_addr_o,
  input  logic                   imem_ready_i,
  input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
  output logic [ADDR_WIDTH-1:0]  pc_o,
  output logic [ADDR_WIDTH-1:0]  if_id_pc_o,
  output logic [INSTR_WIDTH-1:0] if_id_instr_o,
  output logic                   if_id_valid_o
);

  localparam logic [ADDR_WIDTH-1:0] PC_INC = ADDR_WIDTH'(PC_STEP);

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_HOLD    = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]  disc_addr_q, disc_addr_d;
  logic [INSTR_WIDTH-1:0] hold_instr_q, hold_instr_d;
  logic [ADDR_WIDTH-1:0]  if_id_pc_q, if_id_pc_d;
  logic [INSTR_WIDTH-1:0] if_id_instr_q, if_id_instr_d;
  logic                   if_id_valid_q, if_id_valid_d;

  logic                   req;
  logic                   xfer;
  logic [ADDR_WIDTH-1:0]  pc_next;

  // Request is live in FETCH and DISCARD; forced low during the reset cycle.
  assign req     = !reset_i && (state_q != ST_HOLD);
  assign xfer    = req && imem_ready_i;
  assign pc_next = pc_write_i ? (pc_q + PC_INC) : pc_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= ST_FETCH;
      pc_q          <= RESET_PC;
      disc_addr_q   <= '0;
      hold_instr_q  <= '0;
      if_id_pc_q    <= '0;
      if_id_instr_q <= '0;
      if_id_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      disc_addr_q   <= disc_addr_d;
      hold_instr_q  <= hold_instr_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    disc_addr_d   = disc_addr_q;
    hold_instr_d  = hold_instr_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;

    if (branch_taken_i) begin
      // Flush wins over any IF/ID stall.
      if_id_valid_d = 1'b0;
      hold_instr_d  = '0;
      pc_d          = branch_target_i;
      if (req && !imem_ready_i) begin
        state_d = ST_DISCARD;
        // A second redirect while discarding must not disturb the address
        // still presented to memory.
        if (state_q == ST_FETCH) begin
          disc_addr_d = pc_q;
        end
      end else begin
        state_d = ST_FETCH;
      end
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (xfer) begin
            if (if_id_write_i) begin
              if_id_pc_d    = pc_q;
              if_id_instr_d = imem_rdata_i;
              if_id_valid_d = 1'b1;
              pc_d          = pc_next;
            end else begin
              hold_instr_d = imem_rdata_i;
              state_d      = ST_HOLD;
            end
          end else if (if_id_write_i) begin
            if_id_valid_d = 1'b0;
          end
        end
        ST_HOLD: begin
          // The buffered word was fetched from pc_q, which has not moved.
          if (if_id_write_i) begin
            if_id_pc_d    = pc_q;
            if_id_instr_d = hold_instr_q;
            if_id_valid_d = 1'b1;
            pc_d          = pc_next;
            state_d       = ST_FETCH;
          end
        end
        ST_DISCARD: begin
          if (imem_ready_i) begin
            state_d = ST_FETCH;
          end
        end
        default: begin
          state_d = ST_FETCH;
        end
      endcase
    end
  end

  assign imem_req_o    = req;
  assign imem_addr_o   = (state_q == ST_DISCARD) ? disc_addr_q : pc_q;
  assign pc_o          = pc_q;
  assign if_id_pc_o    = if_id_pc_q;
  assign if_id_instr_o = if_id_instr_q;
  assign if_id_valid_o = if_id_valid_q;

endmodule

// File: tb/tb_fetch_stage_controller.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage_controller
//
// Self-checking bench for fetch_stage_controller. A behavioural model tracks
// the fetch front end as "abandoned request pending", a queue of buffered
// instructions and the expected IF/ID contents. Directed scenarios walk the
// fetch / stall / wait / redirect / wrap cases, then a randomized run compares
// the DUT against the model every cycle. Memory returns addr ^ salt.
// -----------------------------------------------------------------------------
module tb_fetch_stage_controller;

  logic        clk;
  logic        reset;
  logic        pc_write;
  logic        if_id_write;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] salt = 32'h0;

  // reference model state
  logic [31:0] m_pc       = 32'h0;
  logic [31:0] m_req_addr = 32'h0;
  logic [31:0] m_id_pc    = 32'h0;
  logic [31:0] m_id_instr = 32'h0;
  bit          m_id_valid = 1'b0;
  bit          m_drop     = 1'b0;
  logic [31:0] m_held[$];

  fetch_stage_controller #(
    .ADDR_WIDTH (32),
    .INSTR_WIDTH(32),
    .RESET_PC   (32'h0),
    .PC_STEP    (4)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .pc_write_i     (pc_write),
    .if_id_write_i  (if_id_write),
    .branch_taken_i (branch_taken),
    .branch_target_i(branch_target),
    .imem_req_o     (imem_req),
    .imem_addr_o    (imem_addr),
    .imem_ready_i   (imem_ready),
    .imem_rdata_i   (imem_rdata),
    .pc_o           (pc),
    .if_id_pc_o     (if_id_pc),
    .if_id_instr_o  (if_id_instr),
    .if_id_valid_o  (if_id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit exp_req();
    return !reset && (m_held.size() == 0);
  endfunction

  function automatic logic [31:0] exp_addr();
    return m_drop ? m_req_addr : m_pc;
  endfunction

  task automatic apply(input bit r, input bit pw, input bit iw, input bit bt,
                       input logic [31:0] tgt, input bit rdy);
    reset         = r;
    pc_write      = pw;
    if_id_write   = iw;
    branch_taken  = bt;
    branch_target = tgt;
    imem_ready    = rdy;
    imem_rdata    = exp_addr() ^ salt;
    #1;
  endtask

  // Advance the model by one cycle from the driven inputs, then clock the DUT.
  task automatic tick();
    bit req;
    bit x;
    req = exp_req();
    x   = req && imem_ready;
    if (reset) begin
      m_pc = 32'h0; m_drop = 1'b0; m_held.delete();
      m_id_pc = 32'h0; m_id_instr = 32'h0; m_id_valid = 1'b0;
    end else if (branch_taken) begin
      m_id_valid = 1'b0;
      if (req && !imem_ready) begin
        if (!m_drop) begin
          m_req_addr = m_pc;
          m_drop     = 1'b1;
        end
      end else begin
        m_drop = 1'b0;
      end
      m_held.delete();
      m_pc = branch_target;
    end else if (m_drop) begin
      if (imem_ready) m_drop = 1'b0;
    end else if (m_held.size() != 0) begin
      if (if_id_write) begin
        m_id_pc    = m_pc;
        m_id_instr = m_held.pop_front();
        m_id_valid = 1'b1;
        if (pc_write) m_pc = m_pc + 32'd4;
      end
    end else if (x) begin
      if (if_id_write) begin
        m_id_pc    = m_pc;
        m_id_instr = imem_rdata;
        m_id_valid = 1'b1;
        if (pc_write) m_pc = m_pc + 32'd4;
      end else begin
        m_held.push_back(imem_rdata);
      end
    end else if (if_id_write) begin
      m_id_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply(1, 1, 1, 0, 32'h0, 1);
    n_vec++;
    if (imem_req !== 1'b0) begin
      n_err++; $display("FAIL reset_req: got %0b want 0", imem_req);
    end
    tick();
    apply(1, 1, 1, 0, 32'h0, 1);
    tick();
    n_vec++;
    if (pc !== 32'h0) begin
      n_err++; $display("FAIL reset_pc: got %h want 0", pc);
    end
    n_vec++;
    if (if_id_valid !== 1'b0 || if_id_pc !== 32'h0 || if_id_instr !== 32'h0) begin
      n_err++; $display("FAIL reset_ifid: got v=%0b pc=%h i=%h want 0/0/0",
                        if_id_valid, if_id_pc, if_id_instr);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 3; i++) begin
      apply(0, 1, 1, 0, 32'h0, 1);
      n_vec++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i)) begin
        n_err++; $display("FAIL stream_req%0d: got req=%0b addr=%h want 1/%h",
                          i, imem_req, imem_addr, 32'(4 * i));
      end
      tick();
      n_vec++;
      if (if_id_valid !== 1'b1 || if_id_pc !== 32'(4 * i) || if_id_instr !== 32'(4 * i)) begin
        n_err++; $display("FAIL stream_ifid%0d: got v=%0b pc=%h i=%h want 1/%h/%h",
                          i, if_id_valid, if_id_pc, if_id_instr, 32'(4 * i), 32'(4 * i));
      end
    end
    n_vec++;
    if (pc !== 32'd12) begin
      n_err++; $display("FAIL stream_pc: got %h want c", pc);
    end
  endtask

  task automatic test_load_use_stall();
    apply(1, 1, 1, 0, 32'h0, 1); tick();
    apply(0, 1, 1, 0, 32'h0, 1); tick();
    apply(0, 1, 1, 0, 32'h0, 1); tick();
    for (int i = 0; i < 2; i++) begin
      apply(0, 0, 0, 0, 32'h0, 1);
      n_vec++;
      if (imem_req !== (i == 0)) begin
        n_err++; $display("FAIL stall_req%0d: got %0b want %0b", i, imem_req, i == 0);
      end
      tick();
      n_vec++;
      if (if_id_valid !== 1'b1 || if_id_pc !== 32'h4 || if_id_instr !== 32'h4 || pc !== 32'h8) begin
        n_err++; $display("FAIL stall_hold%0d: got v=%0b pc=%h i=%h fpc=%h want 1/4/4/8",
                          i, if_id_valid, if_id_pc, if_id_instr, pc);
      end
    end
    apply(0, 1, 1, 0, 32'h0, 1);
    n_vec++;
    if (imem_req !== 1'b0) begin
      n_err++; $display("FAIL stall_release_req: got %0b want 0", imem_req);
    end
    tick();
    n_vec++;
    if (if_id_valid !== 1'b1 || if_id_pc !== 32'h8 || if_id_instr !== 32'h8 || pc !== 32'hc) begin
      n_err++; $display("FAIL stall_release: got v=%0b pc=%h i=%h fpc=%h want 1/8/8/c",
                        if_id_valid, if_id_pc, if_id_instr, pc);
    end
    apply(0, 1, 1, 0, 32'h0, 1);
    n_vec++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hc) begin
      n_err++; $display("FAIL stall_refetch: got req=%0b addr=%h want 1/c", imem_req, imem_addr);
    end
    tick();
    n_vec++;
    if (if_id_valid !== 1'b1 || if_id_pc !== 32'hc || if_id_instr !== 32'hc) begin
      n_err++; $display("FAIL stall_next: got v=%0b pc=%h i=%h want 1/c/c",
                        if_id_valid, if_id_pc, if_id_instr);
    end
  endtask

  task automatic test_mem_wait();
    for (int i = 0; i < 3; i++) begin
      apply(0, 1, 1, 0, 32'h0, 0);
      n_vec++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
        n_err++; $display("FAIL wait_addr%0d: got req=%0b addr=%h want 1/10", i, imem_req, imem_addr);
      end
      tick();
      n_vec++;
      if (if_id_valid !== 1'b0) begin
        n_err++; $display("FAIL wait_bubble%0d: got v=%0b want 0", i, if_id_valid);
      end
    end
    apply(0, 1, 1, 0, 32'h0, 1);
    tick();
    n_vec++;
    if (if_id_valid !== 1'b1 || if_id_pc !== 32'h10 || if_id_instr !== 32'h10 || pc !== 32'h14) begin
      n_err++; $display("FAIL wait_done: got v=%0b pc=%h i=%h fpc=%h want 1/10/10/14",
                        if_id_valid, if_id_pc, if_id_instr, pc);
    end
  endtask

  task automatic test_branch_wait();
    for (int i = 0; i < 3; i++) begin
      apply(0, 1, 1, 0, 32'h0, 1); tick();
    end
    apply(0, 1, 1, 1, 32'h100, 0);
    n_vec++;
    if (imem_addr !== 32'h20) begin
      n_err++; $display("FAIL bw_addr0: got %h want 20", imem_addr);
    end
    tick();
    n_vec++;
    if (if_id_valid !== 1'b0 || pc !== 32'h100) begin
      n_err++; $display("FAIL bw_flush: got v=%0b pc=%h want 0/100", if_id_valid, pc);
    end
    for (int i = 0; i < 2; i++) begin
      apply(0, 1, 1, 0, 32'h0, i == 1);
      n_vec++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin
        n_err++; $display("FAIL bw_hold%0d: got req=%0b addr=%h want 1/20", i, imem_req, imem_addr);
      end
      tick();
      n_vec++;
      if (if_id_valid !== 1'b0 || pc !== 32'h100) begin
        n_err++; $display("FAIL bw_drop%0d: got v=%0b pc=%h want 0/100", i, if_id_valid, pc);
      end
    end
    apply(0, 1, 1, 0, 32'h0, 1);
    n_vec++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      n_err++; $display("FAIL bw_target_req: got req=%0b addr=%h want 1/100", imem_req, imem_addr);
    end
    tick();
    n_vec++;
    if (if_id_valid !== 1'b1 || if_id_pc !== 32'h100 || if_id_instr !== 32'h100) begin
      n_err++; $display("FAIL bw_target: got v=%0b pc=%h i=%h want 1/100/100",
                        if_id_valid, if_id_pc, if_id_instr);
    end
  endtask

  task automatic test_branch_hold();
    apply(0, 0, 0, 0, 32'h0, 1);
    tick();
    apply(0, 0, 0, 1, 32'h200, 1);
    n_vec++;
    if (imem_req !== 1'b0) begin
      n_err++; $display("FAIL bh_req: got %0b want 0", imem_req);
    end
    tick();
    n_vec++;
    if (if_id_valid !== 1'b0 || pc !== 32'h200) begin
      n_err++; $display("FAIL bh_flush: got v=%0b pc=%h want 0/200", if_id_valid, pc);
    end
    apply(0, 1, 1, 0, 32'h0, 1);
    n_vec++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      n_err++; $display("FAIL bh_next: got req=%0b addr=%h want 1/200", imem_req, imem_addr);
    end
    tick();
    n_vec++;
    if (if_id_valid !== 1'b1 || if_id_pc !== 32'h200 || if_id_instr !== 32'h200) begin
      n_err++; $display("FAIL bh_load: got v=%0b pc=%h i=%h want 1/200/200",
                        if_id_valid, if_id_pc, if_id_instr);
    end
  endtask

  task automatic test_wrap();
    apply(0, 1, 1, 1, 32'hFFFF_FFFC, 1);
    tick();
    apply(0, 1, 1, 0, 32'h0, 1);
    n_vec++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      n_err++; $display("FAIL wrap_addr: got %h want fffffffc", imem_addr);
    end
    tick();
    n_vec++;
    if (pc !== 32'h0 || if_id_valid !== 1'b1 || if_id_pc !== 32'hFFFF_FFFC) begin
      n_err++; $display("FAIL wrap_pc: got pc=%h v=%0b ipc=%h want 0/1/fffffffc",
                        pc, if_id_valid, if_id_pc);
    end
  endtask

  task automatic test_reset_in_discard();
    apply(0, 1, 1, 0, 32'h0, 1); tick();
    apply(0, 1, 1, 1, 32'h300, 0); tick();
    apply(1, 1, 1, 0, 32'h0, 0);
    n_vec++;
    if (imem_req !== 1'b0) begin
      n_err++; $display("FAIL rd_req: got %0b want 0", imem_req);
    end
    tick();
    n_vec++;
    if (pc !== 32'h0 || if_id_valid !== 1'b0) begin
      n_err++; $display("FAIL rd_state: got pc=%h v=%0b want 0/0", pc, if_id_valid);
    end
    apply(0, 1, 1, 0, 32'h0, 1);
    n_vec++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_err++; $display("FAIL rd_fetch: got req=%0b addr=%h want 1/0", imem_req, imem_addr);
    end
    tick();
    n_vec++;
    if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0 || pc !== 32'h4) begin
      n_err++; $display("FAIL rd_load: got v=%0b ipc=%h pc=%h want 1/0/4", if_id_valid, if_id_pc, pc);
    end
  endtask

  task automatic test_random();
    bit          r, pw, iw, bt, rdy, ereq;
    int unsigned k;
    logic [31:0] tgt;
    logic [31:0] ea;
    salt = 32'h5A5A_0001;
    apply(1, 1, 1, 0, 32'h0, 1); tick();
    for (int n = 0; n < 3000; n++) begin
      k   = $urandom_range(99);
      pw  = (k >= 25);
      iw  = (k >= 25);
      if (k >= 96) pw = 1'b0;
      r   = ($urandom_range(249) == 0);
      bt  = ($urandom_range(9) == 0);
      tgt = {$urandom_range(32'h3FFF_FFFF), 2'b00};
      rdy = ($urandom_range(9) < 7);
      apply(r, pw, iw, bt, tgt, rdy);
      ereq = exp_req();
      ea   = exp_addr();
      n_vec++;
      if (imem_req !== ereq || (ereq && imem_addr !== ea)) begin
        n_err++; $display("FAIL rnd_req @%0d: got req=%0b addr=%h want %0b/%h",
                          n, imem_req, imem_addr, ereq, ea);
      end
      tick();
      n_vec++;
      if (pc !== m_pc || if_id_valid !== m_id_valid ||
          if_id_pc !== m_id_pc || if_id_instr !== m_id_instr) begin
        n_err++; $display("FAIL rnd_state @%0d: got pc=%h v=%0b ipc=%h i=%h want %h/%0b/%h/%h",
                          n, pc, if_id_valid, if_id_pc, if_id_instr,
                          m_pc, m_id_valid, m_id_pc, m_id_instr);
      end
    end
  endtask

  initial begin
    reset = 1'b1; pc_write = 1'b0; if_id_write = 1'b0; branch_taken = 1'b0;
    branch_target = 32'h0; imem_ready = 1'b0; imem_rdata = 32'h0;
    @(posedge clk);
    #1;
    test_reset();
    test_stream();
    test_load_use_stall();
    test_mem_wait();
    test_branch_wait();
    test_branch_hold();
    test_wrap();
    test_reset_in_discard();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
